// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One shift per cycle for BIN_W cycles; start/busy/done handshake.
module bcd_to_binary_seq #(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned BIN_W  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [BIN_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIN_W-1:0]   bin_out_q, bin_out_d;
   logic               err_q, err_d;

   logic               bad_digit;
   logic [BCD_W-1:0]   bcd_shift;
   logic [BCD_W-1:0]   bcd_fix;
   logic [BIN_W-1:0]   acc_shift;

   always_comb begin
      bad_digit = 1'b0;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (bcd_in[4*d +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   // Digit correction is per nibble with no borrow: a shifted digit >= 8 is always >= 3.
   always_comb begin
      bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
      acc_shift = {bcd_q[0], acc_q[BIN_W-1:1]};
      bcd_fix   = bcd_shift;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (bcd_shift[4*d +: 4] >= 4'd8) bcd_fix[4*d +: 4] = bcd_shift[4*d +: 4] - 4'd3;
      end
   end

   always_comb begin
      state_d   = state_q;
      bcd_d     = bcd_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      bin_out_d = bin_out_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (bad_digit) begin
                  bin_out_d = '0;
                  err_d     = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  bcd_d   = bcd_in;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            bcd_d = bcd_fix;
            acc_d = acc_shift;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               bin_out_d = acc_shift;
               err_d     = 1'b0;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         bcd_q     <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         bin_out_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bcd_q     <= bcd_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         bin_out_q <= bin_out_d;
         err_q     <= err_d;
      end
   end

   assign busy    = (state_q == S_SHIFT);
   assign done    = (state_q == S_DONE);
   assign bin_out = bin_out_q;
   assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq (DIGITS=3, BIN_W=10).
module tb_bcd_to_binary_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] bcd_in;
   logic        busy;
   logic        done;
   logic [9:0]  bin_out;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_to_binary_seq #(
      .DIGITS (3),
      .BIN_W  (10)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .err     (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drives one request and follows it to done; inject_at >= 0 pulses a stray start mid-run.
   task automatic conv(input logic [11:0] bcd, input int exp_bin, input logic exp_err,
                       input int exp_lat, input int inject_at, input string tag);
      int         n;
      int         busy_cnt;
      logic       held;
      logic [9:0] prev_bin;
      logic       prev_err;
      @(negedge clk);
      check({tag, " done_low_before"}, 32'(done), 32'd0);
      prev_bin = bin_out;
      prev_err = err;
      bcd_in   = bcd;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      bcd_in   = 12'h777;
      n        = 0;
      busy_cnt = 0;
      held     = 1'b1;
      while (done !== 1'b1 && n < 40) begin
         if (busy === 1'b1) busy_cnt++;
         if (bin_out !== prev_bin || err !== prev_err) held = 1'b0;
         if (n == inject_at) begin
            start  = 1'b1;
            bcd_in = 12'h001;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check({tag, " latency"}, 32'(n), 32'(exp_lat));
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
      check({tag, " busy_at_done"}, 32'(busy), 32'd0);
      check({tag, " held"}, 32'(held), 32'd1);
      check({tag, " bin_out"}, 32'(bin_out), 32'(exp_bin));
      check({tag, " err"}, 32'(err), 32'(exp_err));
   endtask

   initial begin
      int quiet;
      logic [11:0] v;
      rst    = 1'b1;
      start  = 1'b0;
      bcd_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst bin_out", 32'(bin_out), 32'd0);
      check("rst err", 32'(err), 32'd0);

      conv(12'h999, 999, 1'b0, 10, -1, "h999");
      conv(12'h255, 255, 1'b0, 10, -1, "h255");
      conv(12'h000, 0,   1'b0, 10, -1, "h000");
      conv(12'h128, 128, 1'b0, 10, -1, "h128");

      conv(12'h1A3, 0,  1'b1, 0,  -1, "h1A3_invalid");
      conv(12'h042, 42, 1'b0, 10, -1, "h042_after_invalid");

      conv(12'h999, 999, 1'b0, 10, 3, "h999_stray_start");
      quiet = 0;
      @(negedge clk);
      check("stray done_pulse_width", 32'(done), 32'd0);
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) quiet++;
      end
      check("stray no_second_run", 32'(quiet), 32'd0);
      check("stray bin_out_kept", 32'(bin_out), 32'd999);

      @(negedge clk);
      bcd_in = 12'h999;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort busy_before_rst", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort bin_out", 32'(bin_out), 32'd0);
      check("abort err", 32'(err), 32'd0);
      quiet = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) quiet++;
      end
      check("abort no_done", 32'(quiet), 32'd0);
      conv(12'h042, 42, 1'b0, 10, -1, "h042_after_abort");

      for (int i = 0; i < 1000; i++) begin
         v[11:8] = 4'(i / 100);
         v[7:4]  = 4'((i / 10) % 10);
         v[3:0]  = 4'(i % 10);
         conv(v, i, 1'b0, 10, -1, "sweep");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
